// File: rtl/gato_turn_ctrl.sv
// gato_turn_ctrl: turn sequencer for a 3x3 board game.
// Accepts move requests from players X and O, enforces turn order and cell
// occupancy, writes accepted moves into the board and evaluates win/draw.
// Optional build macro GATO_TURN_TIMEOUT_EN adds a per-turn timeout that
// forfeits the turn after TIMEOUT_CYCLES idle cycles in ESPERA.
module gato_turn_ctrl #(
  parameter int CELL_W         = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nuevo_juego,
  input  logic                jugX_valid,
  input  logic [3:0]          jugX_celda,
  input  logic                jugO_valid,
  input  logic [3:0]          jugO_celda,
  output logic [3*CELL_W-1:0] fila0,
  output logic [3*CELL_W-1:0] fila1,
  output logic [3*CELL_W-1:0] fila2,
  output logic                turno,
  output logic                mov_ok,
  output logic                mov_err,
  output logic [CELL_W-1:0]   ganador,
  output logic                empate,
  output logic                juego_fin
);

  typedef enum logic [1:0] {ESPERA, ESCRIBE, EVALUA, FIN} state_t;
  typedef logic [8:0][CELL_W-1:0] board_t;

  localparam logic [CELL_W-1:0] CODE_X = CELL_W'(1);
  localparam logic [CELL_W-1:0] CODE_O = CELL_W'(2);

  // A timeout shorter than two cycles would forfeit every turn immediately.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("gato_turn_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  state_t            state_q, state_d;
  board_t            board_q, board_d;
  board_t            disp;
  logic              turno_q, turno_d;
  logic [3:0]        idx_q, idx_d;
  logic [CELL_W-1:0] ganador_q, ganador_d;
  logic              empate_q, empate_d;
  logic              mov_err_q, mov_err_d;

`ifdef GATO_TURN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Three equal non-empty cells form a line; returns that cell code or empty.
  function automatic logic [CELL_W-1:0] line_win(input logic [CELL_W-1:0] a,
                                                 input logic [CELL_W-1:0] b,
                                                 input logic [CELL_W-1:0] c);
    return (a != '0 && a == b && b == c) ? a : '0;
  endfunction

  // Scans the 8 lines of the board; first line found wins.
  function automatic logic [CELL_W-1:0] find_winner(input board_t b);
    logic [CELL_W-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      if (w == '0) w = line_win(b[3*r], b[3*r+1], b[3*r+2]);
    end
    for (int c = 0; c < 3; c++) begin
      if (w == '0) w = line_win(b[c], b[c+3], b[c+6]);
    end
    if (w == '0) w = line_win(b[0], b[4], b[8]);
    if (w == '0) w = line_win(b[2], b[4], b[6]);
    return w;
  endfunction

  logic              req_valid;
  logic [3:0]        req_idx;
  logic [CELL_W-1:0] req_cell;
  logic              req_legal;
  logic [CELL_W-1:0] turn_code;
  logic [CELL_W-1:0] win_code;
  logic              board_full;

  // Select the requester whose turn it is and look up the target cell.
  always_comb begin
    req_valid  = turno_q ? jugO_valid : jugX_valid;
    req_idx    = turno_q ? jugO_celda : jugX_celda;
    turn_code  = turno_q ? CODE_O : CODE_X;
    req_cell   = '0;
    for (int i = 0; i < 9; i++) begin
      if (req_idx == 4'(i)) req_cell = board_q[i];
    end
    req_legal  = (req_idx <= 4'd8) && (req_cell == '0);
    win_code   = find_winner(board_q);
    board_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board_q[i] == '0) board_full = 1'b0;
    end
  end

  // Next-state and next-register logic for the turn FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    board_d   = board_q;
    turno_d   = turno_q;
    idx_d     = idx_q;
    ganador_d = ganador_q;
    empate_d  = empate_q;
    mov_err_d = 1'b0;
`ifdef GATO_TURN_TIMEOUT_EN
    cnt_d     = '0;
`endif
    if (nuevo_juego) begin
      // New game wins over anything in flight, including a pending write.
      state_d   = ESPERA;
      board_d   = '0;
      turno_d   = 1'b0;
      ganador_d = '0;
      empate_d  = 1'b0;
    end else begin
      case (state_q)
        ESPERA: begin
          if (req_valid && req_legal) begin
            idx_d   = req_idx;
            state_d = ESCRIBE;
          end else begin
            if (req_valid) mov_err_d = 1'b1;
`ifdef GATO_TURN_TIMEOUT_EN
            // Rejected requests keep counting; only an accept stops the clock.
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              turno_d   = ~turno_q;
              mov_err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`endif
          end
        end
        ESCRIBE: begin
          for (int i = 0; i < 9; i++) begin
            if (idx_q == 4'(i)) board_d[i] = turn_code;
          end
          state_d = EVALUA;
        end
        EVALUA: begin
          // Win is checked before draw so a line on the last move is a win.
          if (win_code != '0) begin
            ganador_d = win_code;
            state_d   = FIN;
          end else if (board_full) begin
            empate_d = 1'b1;
            state_d  = FIN;
          end else begin
            turno_d = ~turno_q;
            state_d = ESPERA;
          end
        end
        FIN:     state_d = FIN;
        default: state_d = ESPERA;
      endcase
    end
  end

  // State and board registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the board is a handful of flops, not a RAM, so it is reset along
    // with the rest of the state; a mid-game reset leaves nothing behind.
    if (!rst_n) begin
      state_q   <= ESPERA;
      board_q   <= '0;
      turno_q   <= 1'b0;
      idx_q     <= '0;
      ganador_q <= '0;
      empate_q  <= 1'b0;
      mov_err_q <= 1'b0;
`ifdef GATO_TURN_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      board_q   <= board_d;
      turno_q   <= turno_d;
      idx_q     <= idx_d;
      ganador_q <= ganador_d;
      empate_q  <= empate_d;
      mov_err_q <= mov_err_d;
`ifdef GATO_TURN_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Board view: the cell being written is visible during ESCRIBE itself.
  always_comb begin
    disp = board_q;
    if (state_q == ESCRIBE) begin
      for (int i = 0; i < 9; i++) begin
        if (idx_q == 4'(i)) disp[i] = turn_code;
      end
    end
  end

  assign fila0     = disp[2:0];
  assign fila1     = disp[5:3];
  assign fila2     = disp[8:6];
  assign turno     = turno_q;
  assign mov_ok    = (state_q == ESCRIBE) && !nuevo_juego;
  assign mov_err   = mov_err_q;
  assign ganador   = ganador_q;
  assign empate    = empate_q;
  assign juego_fin = (state_q == FIN);

endmodule
